riscv_lsu: RTL and testbench
============================

Name: riscv_lsu

Overview:
- Load-store unit that answers the core's data-memory request port (mem_req/mem_we/mem_size/mem_addr/mem_wd, read data back, stall) and drives a word-wide, byte-enabled synchronous data memory with a req/ready handshake.
- Stalls the core for the whole transaction.
- Performs byte/halfword lane steering and load sign/zero extension.
- Detects misaligned accesses and memory timeouts.

Parameters:
- TIMEOUT, 255: maximum BUSY cycles waiting for mem_ready_i before the access is aborted with an error; 0 disables the timeout.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  asynchronous reset, active-low
- core_req_i  in  1  core requests a data access; held stable while core_stall_o=1
- core_we_i  in  1  1=store, 0=load
- core_size_i  in  3  funct3 encoding: 0 LB/SB, 1 LH/SH, 2 LW/SW, 4 LBU, 5 LHU
- core_addr_i  in  32  byte address
- core_wd_i  in  32  store data, in the low lanes
- core_rd_o  out  32  load result, extended
- core_stall_o  out  1  core must hold PC and suppress register-file writes
- core_err_o  out  1  access failed (misaligned, illegal size, or timeout)
- mem_req_o  out  1  memory request
- mem_we_o  out  1  memory write
- mem_be_o  out  4  byte enables
- mem_addr_o  out  32  word-aligned address
- mem_wd_o  out  32  lane-replicated write data
- mem_rd_i  in  32  memory read word; valid when mem_ready_i=1
- mem_ready_i  in  1  memory accepts or completes the request this cycle

Behaviour:
- Reset (async, rst_ni=0): state IDLE; all mem_* outputs 0; core_rd_o=0; core_err_o=0; timeout counter 0.
- core_stall_o = core_req_i & (state != DONE). This is combinational, so a new request stalls in the same cycle it appears.
- IDLE, core_req_i=1:
  - Register we, size, addr and wd.
  - Misaligned or illegal size goes to DONE with error flag set; no memory request is issued.
    - Misaligned: half with addr[0]=1, or word with addr[1:0]≠0.
    - Illegal size: 3, 6 or 7. Stores with size 4 or 5 also count as illegal.
  - Otherwise go to BUSY.
- BUSY:
  - mem_req_o=1 and all mem_* outputs are stable from registers.
  - On mem_ready_i=1:
    - Load: capture the extended read data into core_rd_o.
    - Go to DONE; mem_req_o is 0 in the following cycle.
  - Timeout counter increments every BUSY cycle. When it reaches TIMEOUT with no ready (TIMEOUT≠0), drop mem_req_o, set the error flag and go to DONE.
  - Counter clears on entry to BUSY.
- DONE:
  - core_stall_o=0, so the core advances on this edge.
  - core_err_o equals the error flag for this cycle only.
  - Go to IDLE unconditionally. The error flag clears on leaving DONE.
- Minimum latency is 3 cycles per access: IDLE, BUSY with ready, DONE. Back-to-back accesses each re-enter IDLE.
- Lane steering, with off=addr[1:0]:
  - Byte: be = 1<<off; wd = {4{wd[7:0]}}.
  - Half: be = off[1] ? 1100 : 0011; wd = {2{wd[15:0]}}.
  - Word: be = 1111; wd = wd.
  - The same be pattern is driven for loads.
  - mem_addr_o = {addr[31:2], 2'b00}.
- Load extraction:
  - Byte is lane off; half is lane pair off[1].
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes through.
- core_rd_o holds its last value across stores, errors and idle periods.
- An errored load writes core_rd_o=0.
- If core_req_i drops during BUSY (protocol violation), the memory transaction still completes. The result is discarded (core_rd_o unchanged) and core_stall_o is 0.
- Reset mid-BUSY drops mem_req_o immediately (async). The memory must tolerate an abandoned request.

Test Plan:
- **Aligned word load:** SW 0xDEADBEEF then LW from 0x10; ready after 2 BUSY cycles.
  - Expect be=1111 and mem_addr_o=0x10.
  - Expect core_rd_o=0xDEADBEEF.
  - Expect stall high for 4 cycles, then low for 1.
- **Byte loads from word 0x80F0_7F01 at 0x20:**
  - LB at 0x23 gives 0xFFFFFF80.
  - LBU at 0x23 gives 0x00000080.
  - LB at 0x21 gives 0x0000007F.
  - be=1000 for 0x23.
- **SH at 0x32 with wd=0x1234ABCD:** expect be=1100, mem_wd_o=0xABCDABCD, mem_addr_o=0x30. A following LH at 0x32 gives 0xFFFFABCD; LHU gives 0x0000ABCD.
- **Misaligned LW at 0x41:**
  - mem_req_o never asserts.
  - Stall lasts 1 cycle; core_err_o pulses in DONE.
  - core_rd_o=0.
- **Timeout:** TIMEOUT=4 with mem_ready_i tied 0. Expect mem_req_o high for 4 cycles, core_err_o pulse, and return to IDLE. With TIMEOUT=0 the LSU stalls indefinitely until ready.
- **Reset mid-operation:** assert rst_ni=0 during BUSY. mem_req_o and stall-related state drop asynchronously and core_rd_o=0. After release, an LW completes normally.

Source files
------------

// File: rtl/riscv_lsu.sv
// Load-store unit: turns the core's byte/half/word data requests into
// word-wide, byte-enabled memory transactions with a req/ready handshake.
// Stalls the core for the whole access, steers store lanes, extends loads,
// and flags misaligned/illegal accesses and memory timeouts.
module riscv_lsu #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        core_req_i,
  input  logic        core_we_i,
  input  logic [2:0]  core_size_i,
  input  logic [31:0] core_addr_i,
  input  logic [31:0] core_wd_i,
  output logic [31:0] core_rd_o,
  output logic        core_stall_o,
  output logic        core_err_o,
  output logic        mem_req_o,
  output logic        mem_we_o,
  output logic [3:0]  mem_be_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wd_o,
  input  logic [31:0] mem_rd_i,
  input  logic        mem_ready_i
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e        state_q;
  logic          we_q;
  logic [2:0]    size_q;
  logic [1:0]    off_q;
  logic          err_q;
  logic [CW-1:0] cnt_q;
  logic [31:0]   rd_q;
  logic          mem_req_q, mem_we_q;
  logic [3:0]    be_q;
  logic [31:0]   maddr_q, mwd_q;

  logic          illegal, misal;
  logic [3:0]    be_d;
  logic [31:0]   wd_d;
  logic [7:0]    byte_v;
  logic [15:0]   half_v;
  logic [31:0]   ld_d;
  logic          timeout_hit;

  // Decode the incoming request: legality, alignment and store lane steering
  always_comb begin
    illegal = (core_size_i == 3'd3) || (core_size_i[2:1] == 2'b11) ||
              (core_we_i && core_size_i[2]);
    misal   = ((core_size_i[1:0] == 2'd1) && core_addr_i[0]) ||
              ((core_size_i[1:0] == 2'd2) && (core_addr_i[1:0] != 2'd0));
    case (core_size_i[1:0])
      2'd0: begin
        be_d = 4'b0001 << core_addr_i[1:0];
        wd_d = {4{core_wd_i[7:0]}};
      end
      2'd1: begin
        be_d = core_addr_i[1] ? 4'b1100 : 4'b0011;
        wd_d = {2{core_wd_i[15:0]}};
      end
      default: begin
        be_d = 4'b1111;
        wd_d = core_wd_i;
      end
    endcase
  end

  // Pick the addressed lane(s) out of the returned word and extend them
  always_comb begin
    byte_v = mem_rd_i[{off_q, 3'b000} +: 8];
    half_v = off_q[1] ? mem_rd_i[31:16] : mem_rd_i[15:0];
    case (size_q)
      3'd0:    ld_d = {{24{byte_v[7]}}, byte_v};
      3'd1:    ld_d = {{16{half_v[15]}}, half_v};
      3'd4:    ld_d = {24'd0, byte_v};
      3'd5:    ld_d = {16'd0, half_v};
      default: ld_d = mem_rd_i;
    endcase
    timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);
  end

  // Access sequencer: IDLE -> BUSY -> DONE, or IDLE -> DONE on a bad request
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      we_q      <= 1'b0;
      size_q    <= 3'd0;
      off_q     <= 2'd0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
      rd_q      <= 32'd0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      be_q      <= 4'd0;
      maddr_q   <= 32'd0;
      mwd_q     <= 32'd0;
    end else begin
      case (state_q)
        IDLE: if (core_req_i) begin
          we_q   <= core_we_i;
          size_q <= core_size_i;
          off_q  <= core_addr_i[1:0];
          cnt_q  <= '0;
          if (illegal || misal) begin
            // bad request never reaches memory; a load result reads as zero
            err_q   <= 1'b1;
            state_q <= DONE;
            if (!core_we_i) rd_q <= 32'd0;
          end else begin
            mem_req_q <= 1'b1;
            mem_we_q  <= core_we_i;
            be_q      <= be_d;
            maddr_q   <= {core_addr_i[31:2], 2'b00};
            mwd_q     <= wd_d;
            state_q   <= BUSY;
          end
        end
        BUSY: begin
          cnt_q <= cnt_q + CW'(1);
          // a request withdrawn mid-access still finishes but is not retired
          if (mem_ready_i) begin
            mem_req_q <= 1'b0;
            state_q   <= DONE;
            if (!we_q && core_req_i) rd_q <= ld_d;
          end else if (timeout_hit) begin
            mem_req_q <= 1'b0;
            err_q     <= 1'b1;
            state_q   <= DONE;
            if (!we_q && core_req_i) rd_q <= 32'd0;
          end
        end
        default: begin
          err_q   <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign core_stall_o = core_req_i & (state_q != DONE);
  assign core_err_o   = err_q;
  assign core_rd_o    = rd_q;
  assign mem_req_o    = mem_req_q;
  assign mem_we_o     = mem_we_q;
  assign mem_be_o     = be_q;
  assign mem_addr_o   = maddr_q;
  assign mem_wd_o     = mwd_q;

endmodule

// File: tb/tb_riscv_lsu.sv
// Directed bench for riscv_lsu: table of single accesses with hand-computed
// lane/extension results, plus sequences for timeout, withdrawn request,
// reset mid-access and the no-timeout configuration.
module tb_riscv_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        core_req = 1'b0, core_we = 1'b0;
  logic [2:0]  core_size = 3'd0;
  logic [31:0] core_addr = 32'd0, core_wd = 32'd0;
  logic [31:0] mem_rd = 32'd0;
  logic        mem_ready = 1'b0;

  logic [31:0] core_rd_o, mem_addr_o, mem_wd_o;
  logic        core_stall_o, core_err_o, mem_req_o, mem_we_o;
  logic [3:0]  mem_be_o;

  logic        req0 = 1'b0, ready0 = 1'b0;
  logic [31:0] rd0, maddr0, mwd0;
  logic        stall0, err0, mreq0, mwe0;
  logic [3:0]  be0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  riscv_lsu #(.TIMEOUT(4)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(core_req), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(core_rd_o), .core_stall_o(core_stall_o), .core_err_o(core_err_o),
    .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
    .mem_addr_o(mem_addr_o), .mem_wd_o(mem_wd_o),
    .mem_rd_i(mem_rd), .mem_ready_i(mem_ready)
  );

  riscv_lsu #(.TIMEOUT(0)) dut0 (
    .clk_i(clk), .rst_ni(rst_n),
    .core_req_i(req0), .core_we_i(core_we), .core_size_i(core_size),
    .core_addr_i(core_addr), .core_wd_i(core_wd),
    .core_rd_o(rd0), .core_stall_o(stall0), .core_err_o(err0),
    .mem_req_o(mreq0), .mem_we_o(mwe0), .mem_be_o(be0),
    .mem_addr_o(maddr0), .mem_wd_o(mwd0),
    .mem_rd_i(mem_rd), .mem_ready_i(ready0)
  );

  typedef struct {
    logic        we;
    logic [2:0]  size;
    logic [31:0] addr, wd, mrd;
    int          wait_n;
    logic [3:0]  be;
    logic [31:0] maddr, mwd, rd;
    logic        err;
    int          busy, stall;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One access on the main DUT; memory answers on BUSY cycle wn+1
  task automatic do_access(input logic we, input logic [2:0] sz, input logic [31:0] a,
                           input logic [31:0] wd, input logic [31:0] mrd, input int wn,
                           output logic [3:0] be, output logic [31:0] ma, output logic [31:0] mw,
                           output logic [31:0] rd, output logic mwe, output logic err,
                           output int busy, output int stall);
    bit done;
    done = 0;
    be = 4'd0; ma = 32'd0; mw = 32'd0; rd = 32'd0; mwe = 1'b0; err = 1'b0;
    busy = 0; stall = 0;
    @(negedge clk);
    core_req = 1'b1; core_we = we; core_size = sz; core_addr = a; core_wd = wd;
    mem_rd = mrd; mem_ready = 1'b0;
    for (int c = 0; c < 300 && !done; c++) begin
      #1;
      if (mem_req_o) begin
        busy++;
        be = mem_be_o; ma = mem_addr_o; mw = mem_wd_o; mwe = mem_we_o;
        mem_ready = (busy == wn + 1);
      end else begin
        mem_ready = 1'b0;
      end
      if (core_stall_o) stall++;
      else begin
        err = core_err_o; rd = core_rd_o; done = 1;
      end
      @(negedge clk);
    end
    core_req = 1'b0; mem_ready = 1'b0;
    if (!done) chk("access_bound", 32'd0, 32'd1);
  endtask

  vec_t v[17];

  initial begin
    logic [3:0]  g_be;
    logic [31:0] g_ma, g_mw, g_rd;
    logic        g_we, g_err;
    int          g_busy, g_stall, cnt_req, cnt_stall;

    //            we   sz    addr      wd            mrd          wn   be       maddr    mwd           rd           err  busy stall
    v[0]  = '{1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 32'h0,        2, 4'b1111, 32'h10, 32'hDEADBEEF, 32'h0,        1'b0, 3, 4};
    v[1]  = '{1'b0, 3'd2, 32'h10, 32'h0,        32'hDEADBEEF, 2, 4'b1111, 32'h10, 32'h0,        32'hDEADBEEF, 1'b0, 3, 4};
    v[2]  = '{1'b0, 3'd0, 32'h23, 32'h0,        32'h80F07F01, 0, 4'b1000, 32'h20, 32'h0,        32'hFFFFFF80, 1'b0, 1, 2};
    v[3]  = '{1'b0, 3'd4, 32'h23, 32'h0,        32'h80F07F01, 0, 4'b1000, 32'h20, 32'h0,        32'h00000080, 1'b0, 1, 2};
    v[4]  = '{1'b0, 3'd0, 32'h21, 32'h0,        32'h80F07F01, 0, 4'b0010, 32'h20, 32'h0,        32'h0000007F, 1'b0, 1, 2};
    v[5]  = '{1'b1, 3'd1, 32'h32, 32'h1234ABCD, 32'h0,        1, 4'b1100, 32'h30, 32'hABCDABCD, 32'h0000007F, 1'b0, 2, 3};
    v[6]  = '{1'b0, 3'd1, 32'h32, 32'h0,        32'hABCDABCD, 0, 4'b1100, 32'h30, 32'h0,        32'hFFFFABCD, 1'b0, 1, 2};
    v[7]  = '{1'b0, 3'd5, 32'h32, 32'h0,        32'hABCDABCD, 0, 4'b1100, 32'h30, 32'h0,        32'h0000ABCD, 1'b0, 1, 2};
    v[8]  = '{1'b1, 3'd0, 32'h01, 32'h000000A5, 32'h0,        0, 4'b0010, 32'h00, 32'hA5A5A5A5, 32'h0000ABCD, 1'b0, 1, 2};
    v[9]  = '{1'b0, 3'd2, 32'h41, 32'h0,        32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'h0,        1'b1, 0, 1};
    v[10] = '{1'b0, 3'd5, 32'h06, 32'h0,        32'h5A5A1234, 0, 4'b1100, 32'h04, 32'h0,        32'h00005A5A, 1'b0, 1, 2};
    v[11] = '{1'b1, 3'd1, 32'h03, 32'h1,        32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'h00005A5A, 1'b1, 0, 1};
    v[12] = '{1'b1, 3'd4, 32'h08, 32'h1,        32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'h00005A5A, 1'b1, 0, 1};
    v[13] = '{1'b0, 3'd3, 32'h08, 32'h0,        32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'h0,        1'b1, 0, 1};
    v[14] = '{1'b0, 3'd1, 32'h00, 32'h0,        32'h00008001, 0, 4'b0011, 32'h00, 32'h0,        32'hFFFF8001, 1'b0, 1, 2};
    v[15] = '{1'b0, 3'd4, 32'h02, 32'h0,        32'h00FF0000, 0, 4'b0100, 32'h00, 32'h0,        32'h000000FF, 1'b0, 1, 2};
    v[16] = '{1'b0, 3'd2, 32'h42, 32'h0,        32'h0,        0, 4'b0000, 32'h00, 32'h0,        32'h0,        1'b1, 0, 1};

    // reset state
    @(negedge clk); #1;
    chk("rst_mem_req", {31'd0, mem_req_o}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we_o}, 32'd0);
    chk("rst_mem_be", {28'd0, mem_be_o}, 32'd0);
    chk("rst_mem_addr", mem_addr_o, 32'd0);
    chk("rst_mem_wd", mem_wd_o, 32'd0);
    chk("rst_core_rd", core_rd_o, 32'd0);
    chk("rst_core_err", {31'd0, core_err_o}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 17; i++) begin
      do_access(v[i].we, v[i].size, v[i].addr, v[i].wd, v[i].mrd, v[i].wait_n,
                g_be, g_ma, g_mw, g_rd, g_we, g_err, g_busy, g_stall);
      chk($sformatf("v%0d_be", i), {28'd0, g_be}, {28'd0, v[i].be});
      chk($sformatf("v%0d_maddr", i), g_ma, v[i].maddr);
      chk($sformatf("v%0d_mwd", i), g_mw, v[i].mwd);
      chk($sformatf("v%0d_mwe", i), {31'd0, g_we}, {31'd0, v[i].we & (v[i].busy > 0)});
      chk($sformatf("v%0d_rd", i), g_rd, v[i].rd);
      chk($sformatf("v%0d_err", i), {31'd0, g_err}, {31'd0, v[i].err});
      chk($sformatf("v%0d_busy", i), g_busy, v[i].busy);
      chk($sformatf("v%0d_stall", i), g_stall, v[i].stall);
    end

    // timeout: good load first so the zeroing is visible, then no ready
    do_access(1'b0, 3'd2, 32'h14, 32'h0, 32'h0BADF00D, 0, g_be, g_ma, g_mw, g_rd, g_we, g_err, g_busy, g_stall);
    chk("pre_to_rd", g_rd, 32'h0BADF00D);
    do_access(1'b0, 3'd2, 32'h10, 32'h0, 32'h12345678, 1000, g_be, g_ma, g_mw, g_rd, g_we, g_err, g_busy, g_stall);
    chk("to_busy", g_busy, 32'd4);
    chk("to_err", {31'd0, g_err}, 32'd1);
    chk("to_stall", g_stall, 32'd5);
    chk("to_rd", g_rd, 32'd0);
    #1 chk("to_err_pulse", {31'd0, core_err_o}, 32'd0);
    do_access(1'b0, 3'd2, 32'h18, 32'h0, 32'h13579BDF, 0, g_be, g_ma, g_mw, g_rd, g_we, g_err, g_busy, g_stall);
    chk("post_to_rd", g_rd, 32'h13579BDF);
    chk("post_to_err", {31'd0, g_err}, 32'd0);

    // request withdrawn mid-BUSY: transaction finishes, result discarded
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h1C; core_wd = 32'h0;
    @(negedge clk); #1;
    chk("drop_busy_req", {31'd0, mem_req_o}, 32'd1);
    core_req = 1'b0; #1;
    chk("drop_stall", {31'd0, core_stall_o}, 32'd0);
    mem_rd = 32'hFFFFFFFF; mem_ready = 1'b1;
    @(negedge clk); #1;
    mem_ready = 1'b0;
    chk("drop_req_off", {31'd0, mem_req_o}, 32'd0);
    @(negedge clk); #1;
    chk("drop_rd_kept", core_rd_o, 32'h13579BDF);
    chk("drop_err", {31'd0, core_err_o}, 32'd0);

    // async reset while BUSY
    @(negedge clk);
    core_req = 1'b1; core_we = 1'b0; core_size = 3'd2; core_addr = 32'h20;
    @(negedge clk); #1;
    chk("rstb_req_before", {31'd0, mem_req_o}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rstb_req", {31'd0, mem_req_o}, 32'd0);
    chk("rstb_rd", core_rd_o, 32'd0);
    chk("rstb_be", {28'd0, mem_be_o}, 32'd0);
    @(negedge clk); core_req = 1'b0; rst_n = 1'b1;
    do_access(1'b0, 3'd2, 32'h24, 32'h0, 32'hCAFEF00D, 1, g_be, g_ma, g_mw, g_rd, g_we, g_err, g_busy, g_stall);
    chk("rstb_after_rd", g_rd, 32'hCAFEF00D);
    chk("rstb_after_busy", g_busy, 32'd2);
    chk("rstb_after_stall", g_stall, 32'd3);

    // TIMEOUT=0 instance waits indefinitely
    @(negedge clk);
    core_we = 1'b0; core_size = 3'd2; core_addr = 32'h10; req0 = 1'b1;
    cnt_req = 0; cnt_stall = 0;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mreq0) cnt_req++;
      if (stall0) cnt_stall++;
      @(negedge clk);
    end
    chk("nto_req_cycles", cnt_req, 32'd39);
    chk("nto_stall_cycles", cnt_stall, 32'd40);
    mem_rd = 32'h600DF00D; ready0 = 1'b1;
    @(negedge clk); #1;
    ready0 = 1'b0;
    chk("nto_stall_done", {31'd0, stall0}, 32'd0);
    chk("nto_err", {31'd0, err0}, 32'd0);
    chk("nto_rd", rd0, 32'h600DF00D);
    @(negedge clk); req0 = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
